// File: rtl/fp_special_unit.sv
// Two-stage IEEE-754 operand classifier and special-result predictor for add/sub/mul/div.
// Define FP_SPECIAL_DAZ_EN to treat subnormal operands as signed zeros (denormals-are-zero).
module fp_special_unit #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  localparam int W     = EXP_W + FRAC_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   out_class_a,
  output logic [5:0]   out_class_b,
  output logic         out_bypass,
  output logic [W-1:0] out_result,
  output logic         out_invalid,
  output logic         out_divzero,
  input  logic         flag_clr,
  output logic         sticky_invalid,
  output logic         sticky_divzero
);

  localparam int C_SNAN = 5;
  localparam int C_QNAN = 4;
  localparam int C_INF  = 3;
  localparam int C_NORM = 2;
  localparam int C_SUB  = 1;
  localparam int C_ZERO = 0;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  function automatic logic [5:0] classify(input logic [W-2:0] mag);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic [5:0]        c;
    e = mag[W-2:FRAC_W];
    f = mag[FRAC_W-1:0];
    c = '0;
    if (&e) begin
      if (f == '0)            c[C_INF]  = 1'b1;
      else if (f[FRAC_W-1])   c[C_QNAN] = 1'b1;
      else                    c[C_SNAN] = 1'b1;
    end else if (e == '0) begin
      if (f == '0) begin
        c[C_ZERO] = 1'b1;
      end else begin
`ifdef FP_SPECIAL_DAZ_EN
        c[C_ZERO] = 1'b1;
`else
        c[C_SUB]  = 1'b1;
`endif
      end
    end else begin
      c[C_NORM] = 1'b1;
    end
    return c;
  endfunction

  function automatic logic [W-1:0] mk_inf(input logic s);
    return {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  endfunction

  function automatic logic [W-1:0] mk_zero(input logic s);
    return {s, {(W-1){1'b0}}};
  endfunction

  // Handshake: stage 1 may advance whenever stage 2 is empty or draining.
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic adv1;
  logic out_fire;

  assign adv1      = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | adv1;
  assign out_fire  = s2_valid_q & out_ready;
  assign out_valid = s2_valid_q;

  // Per-operand classification of the incoming pair.
  logic [W-2:0] in_mag [2];
  logic [5:0]   in_cls [2];

  assign in_mag[0] = in_a[W-2:0];
  assign in_mag[1] = in_b[W-2:0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
      assign in_cls[gi] = classify(in_mag[gi]);
    end
  endgenerate

  // Stage 1 state
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  logic [1:0]   s1_op_q, s1_op_d;
  logic [5:0]   s1_cls_a_q, s1_cls_a_d;
  logic [5:0]   s1_cls_b_q, s1_cls_b_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      s1_a_d     = in_a;
      s1_b_d     = in_b;
      s1_op_d    = in_op;
      s1_cls_a_d = in_cls[0];
      s1_cls_b_d = in_cls[1];
    end
  end

  // Special-value decision from the stage-1 registers
  logic a_sign, b_sign, sb_eff, s_prod;
  logic a_snan, b_snan, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_sign = s1_a_q[W-1];
  assign b_sign = s1_b_q[W-1];
  assign sb_eff = b_sign ^ (s1_op_q == OP_SUB);
  assign s_prod = a_sign ^ b_sign;
  assign a_snan = s1_cls_a_q[C_SNAN];
  assign b_snan = s1_cls_b_q[C_SNAN];
  assign a_nan  = s1_cls_a_q[C_SNAN] | s1_cls_a_q[C_QNAN];
  assign b_nan  = s1_cls_b_q[C_SNAN] | s1_cls_b_q[C_QNAN];
  assign a_inf  = s1_cls_a_q[C_INF];
  assign b_inf  = s1_cls_b_q[C_INF];
  assign a_zero = s1_cls_a_q[C_ZERO];
  assign b_zero = s1_cls_b_q[C_ZERO];

  logic         spc_bypass;
  logic [W-1:0] spc_result;
  logic         spc_invalid;
  logic         spc_divzero;

  always_comb begin
    spc_bypass  = 1'b1;
    spc_result  = '0;
    spc_invalid = 1'b0;
    spc_divzero = 1'b0;
    if (a_snan | b_snan) begin
      spc_result  = QNAN;
      spc_invalid = 1'b1;
    end else begin
      case (s1_op_q)
        OP_ADD, OP_SUB: begin
          if (a_nan | b_nan) begin
            spc_result = QNAN;
          end else if (a_inf & b_inf & (a_sign ^ sb_eff)) begin
            spc_result  = QNAN;
            spc_invalid = 1'b1;
          end else if (a_inf) begin
            spc_result = mk_inf(a_sign);
          end else if (b_inf) begin
            spc_result = mk_inf(sb_eff);
          end else if (a_zero & b_zero) begin
            spc_result = mk_zero(a_sign & sb_eff);
          end else if (a_zero) begin
            spc_result = {sb_eff, s1_b_q[W-2:0]};
          end else if (b_zero) begin
            spc_result = s1_a_q;
          end else begin
            spc_bypass = 1'b0;
          end
        end
        OP_MUL: begin
          if (a_nan | b_nan) begin
            spc_result = QNAN;
          end else if ((a_zero & b_inf) | (a_inf & b_zero)) begin
            spc_result  = QNAN;
            spc_invalid = 1'b1;
          end else if (a_inf | b_inf) begin
            spc_result = mk_inf(s_prod);
          end else if (a_zero | b_zero) begin
            spc_result = mk_zero(s_prod);
          end else begin
            spc_bypass = 1'b0;
          end
        end
        default: begin
          // Rule order makes A finite and nonzero by the time B==0 is tested.
          if (a_nan | b_nan) begin
            spc_result = QNAN;
          end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
            spc_result  = QNAN;
            spc_invalid = 1'b1;
          end else if (a_inf) begin
            spc_result = mk_inf(s_prod);
          end else if (b_zero) begin
            spc_result  = mk_inf(s_prod);
            spc_divzero = 1'b1;
          end else if (a_zero | b_inf) begin
            spc_result = mk_zero(s_prod);
          end else begin
            spc_bypass = 1'b0;
          end
        end
      endcase
    end
  end

  // Stage 2 state: everything visible on the out_* ports
  logic [5:0]   out_class_a_q, out_class_a_d;
  logic [5:0]   out_class_b_q, out_class_b_d;
  logic         out_bypass_q, out_bypass_d;
  logic [W-1:0] out_result_q, out_result_d;
  logic         out_invalid_q, out_invalid_d;
  logic         out_divzero_q, out_divzero_d;
  logic         sticky_inv_q, sticky_inv_d;
  logic         sticky_dz_q, sticky_dz_d;

  always_comb begin
    s2_valid_d    = s2_valid_q;
    out_class_a_d = out_class_a_q;
    out_class_b_d = out_class_b_q;
    out_bypass_d  = out_bypass_q;
    out_result_d  = out_result_q;
    out_invalid_d = out_invalid_q;
    out_divzero_d = out_divzero_q;
    if (adv1) begin
      s2_valid_d    = s1_valid_q;
      out_class_a_d = s1_cls_a_q;
      out_class_b_d = s1_cls_b_q;
      out_bypass_d  = spc_bypass;
      out_result_d  = spc_result;
      out_invalid_d = spc_invalid;
      out_divzero_d = spc_divzero;
    end
    // Set dominates a simultaneous clear.
    sticky_inv_d = (sticky_inv_q & ~flag_clr) | (out_fire & out_invalid_q);
    sticky_dz_d  = (sticky_dz_q  & ~flag_clr) | (out_fire & out_divzero_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_op_q       <= '0;
      s1_cls_a_q    <= '0;
      s1_cls_b_q    <= '0;
      s2_valid_q    <= 1'b0;
      out_class_a_q <= '0;
      out_class_b_q <= '0;
      out_bypass_q  <= 1'b0;
      out_result_q  <= '0;
      out_invalid_q <= 1'b0;
      out_divzero_q <= 1'b0;
      sticky_inv_q  <= 1'b0;
      sticky_dz_q   <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_op_q       <= s1_op_d;
      s1_cls_a_q    <= s1_cls_a_d;
      s1_cls_b_q    <= s1_cls_b_d;
      s2_valid_q    <= s2_valid_d;
      out_class_a_q <= out_class_a_d;
      out_class_b_q <= out_class_b_d;
      out_bypass_q  <= out_bypass_d;
      out_result_q  <= out_result_d;
      out_invalid_q <= out_invalid_d;
      out_divzero_q <= out_divzero_d;
      sticky_inv_q  <= sticky_inv_d;
      sticky_dz_q   <= sticky_dz_d;
    end
  end

  assign out_class_a    = out_class_a_q;
  assign out_class_b    = out_class_b_q;
  assign out_bypass     = out_bypass_q;
  assign out_result     = out_result_q;
  assign out_invalid    = out_invalid_q;
  assign out_divzero    = out_divzero_q;
  assign sticky_invalid = sticky_inv_q;
  assign sticky_divzero = sticky_dz_q;

endmodule

// File: tb/tb_fp_special_unit.sv
// Randomized and directed bench for fp_special_unit (single precision) with a scoreboard
// fed by a rule-level reference model; honours FP_SPECIAL_DAZ_EN when defined.
module tb_fp_special_unit;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] INF  = 32'h7F800000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_class_a, out_class_b;
  logic        out_bypass;
  logic [31:0] out_result;
  logic        out_invalid, out_divzero;
  logic        flag_clr = 1'b0;
  logic        sticky_invalid, sticky_divzero;

  fp_special_unit #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class_a(out_class_a), .out_class_b(out_class_b),
    .out_bypass(out_bypass), .out_result(out_result),
    .out_invalid(out_invalid), .out_divzero(out_divzero),
    .flag_clr(flag_clr),
    .sticky_invalid(sticky_invalid), .sticky_divzero(sticky_divzero)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int out_count = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  typedef struct packed {
    logic [5:0]  ca;
    logic [5:0]  cb;
    logic        byp;
    logic [31:0] res;
    logic        inv;
    logic        dz;
  } exp_t;

  // Class from numeric field values: {snan,qnan,inf,normal,subnormal,zero}
  function automatic logic [5:0] ref_class(input logic [31:0] x);
    int unsigned e, f;
    e = 32'(x[30:23]);
    f = 32'(x[22:0]);
    if (e == 255) begin
      if (f == 0) return 6'b001000;
      if (f >= 32'h400000) return 6'b010000;
      return 6'b100000;
    end
    if (e == 0) begin
      if (f == 0) return 6'b000001;
`ifdef FP_SPECIAL_DAZ_EN
      return 6'b000001;
`else
      return 6'b000010;
`endif
    end
    return 6'b000100;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    exp_t r;
    logic an, bn, ai, bi, az, bz, sa, sbv, se, sp;
    r.ca = ref_class(a);
    r.cb = ref_class(b);
    an = r.ca[5] | r.ca[4];
    bn = r.cb[5] | r.cb[4];
    ai = r.ca[3]; bi = r.cb[3];
    az = r.ca[0]; bz = r.cb[0];
    sa = a[31]; sbv = b[31]; sp = sa ^ sbv;
    r.byp = 1'b1; r.res = '0; r.inv = 1'b0; r.dz = 1'b0;
    if (r.ca[5] || r.cb[5]) begin
      r.res = QNAN; r.inv = 1'b1;
    end else if (op == 2'd0 || op == 2'd1) begin
      se = sbv ^ (op == 2'd1);
      if (an || bn) r.res = QNAN;
      else if (ai && bi && (sa != se)) begin r.res = QNAN; r.inv = 1'b1; end
      else if (ai) r.res = INF | {sa, 31'b0};
      else if (bi) r.res = INF | {se, 31'b0};
      else if (az && bz) r.res = {sa & se, 31'b0};
      else if (az) r.res = {se, b[30:0]};
      else if (bz) r.res = a;
      else r.byp = 1'b0;
    end else if (op == 2'd2) begin
      if (an || bn) r.res = QNAN;
      else if ((az && bi) || (ai && bz)) begin r.res = QNAN; r.inv = 1'b1; end
      else if (ai || bi) r.res = INF | {sp, 31'b0};
      else if (az || bz) r.res = {sp, 31'b0};
      else r.byp = 1'b0;
    end else begin
      if (an || bn) r.res = QNAN;
      else if ((az && bz) || (ai && bi)) begin r.res = QNAN; r.inv = 1'b1; end
      else if (ai) r.res = INF | {sp, 31'b0};
      else if (bz) begin r.res = INF | {sp, 31'b0}; r.dz = 1'b1; end
      else if (az || bi) r.res = {sp, 31'b0};
      else r.byp = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 6))
      0: return {s, 31'b0};
      1: return {s, 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      2: return {s, 8'hFF, 23'b0};
      3: return {s, 8'hFF, 1'b1, 22'($urandom)};
      4: return {s, 8'hFF, 1'b0, 22'($urandom_range(1, 32'h3FFFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Scoreboard, hold-stability and sticky-flag monitor, sampled on the falling edge.
  exp_t exp_q[$];

  initial begin
    exp_t e;
    logic [63:0] held, snap;
    logic held_v;
    logic st_inv, st_dz;
    held_v = 1'b0; st_inv = 1'b0; st_dz = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      snap = {16'b0, out_valid, out_class_a, out_class_b, out_bypass, out_result, out_invalid, out_divzero};
      if (rst) begin
        exp_q.delete();
        held_v = 1'b0; st_inv = 1'b0; st_dz = 1'b0;
      end else begin
        chk("sticky_invalid", 64'(sticky_invalid), 64'(st_inv));
        chk("sticky_divzero", 64'(sticky_divzero), 64'(st_dz));
        if (held_v) chk("hold_stable", snap, held);
        if (flag_clr) begin st_inv = 1'b0; st_dz = 1'b0; end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            out_count++;
            chk("class_a", 64'(out_class_a), 64'(e.ca));
            chk("class_b", 64'(out_class_b), 64'(e.cb));
            chk("bypass", 64'(out_bypass), 64'(e.byp));
            chk("result", 64'(out_result), 64'(e.res));
            chk("invalid", 64'(out_invalid), 64'(e.inv));
            chk("divzero", 64'(out_divzero), 64'(e.dz));
            if (e.inv) st_inv = 1'b1;
            if (e.dz) st_dz = 1'b1;
            $display("out %0d: ca=%b cb=%b byp=%b res=%h inv=%b dz=%b",
                     out_count, out_class_a, out_class_b, out_bypass, out_result, out_invalid, out_divzero);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(ref_model(in_a, in_b, in_op));
        held_v = out_valid && !out_ready;
        held = snap;
      end
    end
  end

  // Present one pair on an idle pipe and wait (bounded) for its result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int lat;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd2);
  endtask

  initial begin
    logic [31:0] bp_a [4];
    logic [31:0] bp_b [4];
    logic [1:0]  bp_op [4];
    int idx, cnt0, acc_before_stall;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    chk("rst_class_a", 64'(out_class_a), 64'd0);
    chk("rst_class_b", 64'(out_class_b), 64'd0);
    chk("rst_flags", 64'({out_bypass, out_invalid, out_divzero, sticky_invalid, sticky_divzero}), 64'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    issue(32'h7F800000, 32'hFF800000, 2'd0);
    chk("t1_bypass", 64'(out_bypass), 64'd1);
    chk("t1_result", 64'(out_result), 64'h7FC00000);
    chk("t1_invalid", 64'(out_invalid), 64'd1);
    @(posedge clk); #1;
    chk("t1_sticky", 64'(sticky_invalid), 64'd1);

    issue(32'h3F800000, 32'h80000000, 2'd3);
    chk("t2_result", 64'(out_result), 64'hFF800000);
    chk("t2_divzero", 64'(out_divzero), 64'd1);
    chk("t2_invalid", 64'(out_invalid), 64'd0);
    chk("t2_class_b", 64'(out_class_b), 64'b000001);
    @(posedge clk); #1;

    issue(32'h7F800001, 32'h3F800000, 2'd2);
    chk("t3_class_a", 64'(out_class_a), 64'b100000);
    chk("t3_invalid", 64'(out_invalid), 64'd1);
    chk("t3_result", 64'(out_result), 64'h7FC00000);
    @(posedge clk); #1;

    issue(32'h00000000, 32'h40000000, 2'd1);
    chk("t4_bypass", 64'(out_bypass), 64'd1);
    chk("t4_result", 64'(out_result), 64'hC0000000);
    @(posedge clk); #1;

    issue(32'h3F800000, 32'h00000001, 2'd3);
`ifdef FP_SPECIAL_DAZ_EN
    chk("daz_divzero", 64'(out_divzero), 64'd1);
    chk("daz_result", 64'(out_result), 64'h7F800000);
`else
    chk("sub_bypass", 64'(out_bypass), 64'd0);
    chk("sub_class_b", 64'(out_class_b), 64'b000010);
    chk("sub_result", 64'(out_result), 64'd0);
`endif
    @(posedge clk); #1;

    // Clear coinciding with an accepted invalid result: set wins, then a lone clear drops it.
    issue(32'h7F800000, 32'hFF800000, 2'd0);
    flag_clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_set_wins", 64'(sticky_invalid), 64'd1);
    @(posedge clk); #1;
    flag_clr = 1'b0;
    chk("clr_alone_inv", 64'(sticky_invalid), 64'd0);
    chk("clr_alone_dz", 64'(sticky_divzero), 64'd0);

    // Four back-to-back pairs with the sink stalled for three cycles.
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = rand_op(); bp_b[i] = rand_op(); bp_op[i] = 2'(i);
    end
    cnt0 = out_count; idx = 0; acc_before_stall = -1;
    for (int c = 0; c < 30 && (idx < 4 || out_count - cnt0 < 4); c++) begin
      out_ready = (c >= 3);
      in_valid = (idx < 4);
      in_a = bp_a[idx % 4]; in_b = bp_b[idx % 4]; in_op = bp_op[idx % 4];
      #1;
      if (c == 2) begin
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        acc_before_stall = idx;
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted_before_stall", 64'(acc_before_stall), 64'd2);
    chk("bp_emitted", 64'(out_count - cnt0), 64'd4);

    // Reset with two pairs in flight: nothing may emerge afterwards.
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h7F800000; in_b = 32'h3F800000; in_op = 2'd2;
    @(posedge clk); #1;
    in_a = 32'h00000000; in_b = 32'h00000000; in_op = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rst_no_emit", 64'(out_valid), 64'd0);
    end

    // Randomized traffic with random backpressure and occasional clears.
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_a = rand_op(); in_b = rand_op(); in_op = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      flag_clr = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flag_clr = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
